// File: rtl/mc_control.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback,
// runs the instruction/data memory handshakes, counts retired instructions and traps on faults.
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_CNT_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_funct3,
  input  logic [5:0]           i_format,
  input  logic                 i_branch_taken,
  input  logic                 i_imem_ready,
  input  logic                 i_dmem_ready,
  output logic                 o_imem_req,
  output logic                 o_ir_write,
  output logic                 o_dmem_req,
  output logic                 o_mem_write,
  output logic                 o_reg_write,
  output logic [1:0]           o_reg_write_src,
  output logic [2:0]           o_alu_op,
  output logic                 o_alu_src,
  output logic [2:0]           o_branch_op,
  output logic                 o_pc_write,
  output logic                 o_pc_src,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause,
  output logic [RET_CNT_W-1:0] o_instret
);

  localparam int unsigned     TO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [1:0] CAUSE_FMT  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM = 2'b10;
  localparam logic [1:0] CAUSE_DMEM = 2'b11;
  localparam logic [1:0] SRC_MEM    = 2'b00;
  localparam logic [1:0] SRC_PC4    = 2'b01;
  localparam logic [1:0] SRC_ALU    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  state_e               state_q, state_d;
  logic [6:0]           opcode_q;
  logic [2:0]           funct3_q;
  logic [5:0]           format_q;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [RET_CNT_W-1:0] instret_q, instret_d;

  logic fmt_r, fmt_i, fmt_s, fmt_b, fmt_j;
  logic is_load, is_link, fmt_onehot, wait_expired;

  assign fmt_r   = format_q[0];
  assign fmt_i   = format_q[1];
  assign fmt_s   = format_q[2];
  assign fmt_b   = format_q[3];
  assign fmt_j   = format_q[5];
  assign is_load = (opcode_q == OP_LOAD);
  assign is_link = fmt_j | (opcode_q == OP_JALR);

  // Format is checked on the live decode input, the same cycle it is captured.
  assign fmt_onehot   = (i_format != '0) && ((i_format & (i_format - 6'd1)) == '0);
  assign wait_expired = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  assign o_trap       = (state_q == S_TRAP);
  assign o_trap_cause = cause_q;
  assign o_instret    = instret_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      funct3_q  <= '0;
      format_q  <= '0;
      to_cnt_q  <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      if (state_q == S_DECODE) begin
        opcode_q <= i_opcode;
        funct3_q <= i_funct3;
        format_q <= i_format;
      end
    end
  end

  // NOTE: every value driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    to_cnt_d        = '0;
    cause_d         = cause_q;
    instret_d       = instret_q;
    o_imem_req      = 1'b0;
    o_ir_write      = 1'b0;
    o_dmem_req      = 1'b0;
    o_mem_write     = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_write_src = SRC_MEM;
    o_alu_op        = '0;
    o_alu_src       = 1'b0;
    o_branch_op     = '0;
    o_pc_write      = 1'b0;
    o_pc_src        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_ir_write = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        if (fmt_onehot) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_FMT;
        end
      end

      S_EXEC: begin
        o_alu_op    = (fmt_r | fmt_i) ? funct3_q : 3'b000;
        o_alu_src   = ~(fmt_r | fmt_b);
        o_branch_op = fmt_b ? funct3_q : 3'b000;
        if (fmt_b) begin
          o_pc_write = 1'b1;
          o_pc_src   = i_branch_taken;
          instret_d  = instret_q + RET_CNT_W'(1);
          state_d    = S_FETCH;
        end else if (is_load | fmt_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        o_dmem_req  = 1'b1;
        o_mem_write = fmt_s;
        if (i_dmem_ready) begin
          if (fmt_s) begin
            o_pc_write = 1'b1;
            instret_d  = instret_q + RET_CNT_W'(1);
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_WB: begin
        o_reg_write     = 1'b1;
        o_reg_write_src = is_link ? SRC_PC4 : (is_load ? SRC_MEM : SRC_ALU);
        o_pc_write      = 1'b1;
        o_pc_src        = is_link;
        instret_d       = instret_q + RET_CNT_W'(1);
        state_d         = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed and random instruction streams checked
// phase by phase against the instruction-class rules, plus trap, timeout and reset cases.
module tb_mc_control;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 4;

  typedef enum {K_R, K_I, K_LOAD, K_S, K_B, K_U, K_J, K_JALR} kind_e;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic [6:0]    i_opcode = '0;
  logic [2:0]    i_funct3 = '0;
  logic [5:0]    i_format = '0;
  logic          i_branch_taken = 1'b0;
  logic          i_imem_ready = 1'b0;
  logic          i_dmem_ready = 1'b0;
  logic          o_imem_req, o_ir_write, o_dmem_req, o_mem_write, o_reg_write;
  logic [1:0]    o_reg_write_src;
  logic [2:0]    o_alu_op;
  logic          o_alu_src;
  logic [2:0]    o_branch_op;
  logic          o_pc_write, o_pc_src, o_trap;
  logic [1:0]    o_trap_cause;
  logic [CW-1:0] o_instret;

  always #5 i_clk = ~i_clk;

  mc_control #(.MEM_TIMEOUT(TO), .RET_CNT_W(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_opcode       (i_opcode),
    .i_funct3       (i_funct3),
    .i_format       (i_format),
    .i_branch_taken (i_branch_taken),
    .i_imem_ready   (i_imem_ready),
    .i_dmem_ready   (i_dmem_ready),
    .o_imem_req     (o_imem_req),
    .o_ir_write     (o_ir_write),
    .o_dmem_req     (o_dmem_req),
    .o_mem_write    (o_mem_write),
    .o_reg_write    (o_reg_write),
    .o_reg_write_src(o_reg_write_src),
    .o_alu_op       (o_alu_op),
    .o_alu_src      (o_alu_src),
    .o_branch_op    (o_branch_op),
    .o_pc_write     (o_pc_write),
    .o_pc_src       (o_pc_src),
    .o_trap         (o_trap),
    .o_trap_cause   (o_trap_cause),
    .o_instret      (o_instret)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_instret = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] strobes();
    return {o_imem_req, o_ir_write, o_dmem_req, o_mem_write, o_reg_write, o_reg_write_src,
            o_alu_op, o_alu_src, o_branch_op, o_pc_write, o_pc_src};
  endfunction

  task automatic encode(input kind_e k, output logic [6:0] op, output logic [5:0] fmt);
    case (k)
      K_R:     begin op = 7'b0110011; fmt = 6'b000001; end
      K_I:     begin op = 7'b0010011; fmt = 6'b000010; end
      K_LOAD:  begin op = 7'b0000011; fmt = 6'b000010; end
      K_S:     begin op = 7'b0100011; fmt = 6'b000100; end
      K_B:     begin op = 7'b1100011; fmt = 6'b001000; end
      K_U:     begin op = 7'b0110111; fmt = 6'b010000; end
      K_J:     begin op = 7'b1101111; fmt = 6'b100000; end
      default: begin op = 7'b1100111; fmt = 6'b000010; end
    endcase
  endtask

  // Asserts reset wherever the bench currently is, then walks through the idle cycle.
  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check("rst_quiet", strobes(), 16'h0);
    check("rst_trap", {o_trap, o_trap_cause}, 3'b000);
    check("rst_instret", o_instret, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
    #1;
    check("idle_quiet", strobes(), 16'h0);
    exp_instret = '0;
    @(negedge i_clk);
  endtask

  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input logic [5:0] fmt,
                              input int fw);
    i_opcode = op;
    i_funct3 = f3;
    i_format = fmt;
    i_dmem_ready = 1'b0;
    i_branch_taken = 1'b0;
    for (int c = 0; c <= fw; c++) begin
      i_imem_ready = (c == fw);
      #1;
      check("fetch_req", o_imem_req, 1);
      check("fetch_ir_write", o_ir_write, (c == fw));
      check("fetch_no_pc", o_pc_write, 0);
      @(negedge i_clk);
    end
    i_imem_ready = 1'b0;
    #1;
    check("decode_quiet", strobes(), 16'h0);
    check("decode_instret", o_instret, exp_instret);
    @(negedge i_clk);
  endtask

  task automatic run_instr(input kind_e k, input logic [2:0] f3, input int fw, input int mw,
                           input logic taken);
    logic [6:0] op;
    logic [5:0] fmt;
    logic       uses_mem, writes_rd, links;
    encode(k, op, fmt);
    uses_mem  = (k == K_LOAD) || (k == K_S);
    writes_rd = !((k == K_S) || (k == K_B));
    links     = (k == K_J) || (k == K_JALR);
    fetch_decode(op, f3, fmt, fw);

    i_branch_taken = taken;
    #1;
    check("exec_alu_op", o_alu_op, (k inside {K_R, K_I, K_LOAD, K_JALR}) ? f3 : 3'b000);
    check("exec_alu_src", o_alu_src, !((k == K_R) || (k == K_B)));
    check("exec_branch_op", o_branch_op, (k == K_B) ? f3 : 3'b000);
    check("exec_pc_write", o_pc_write, (k == K_B));
    check("exec_pc_src", o_pc_src, (k == K_B) && taken);
    check("exec_no_access", {o_imem_req, o_dmem_req, o_mem_write, o_reg_write}, 4'b0);
    if (k == K_B) exp_instret++;
    @(negedge i_clk);
    i_branch_taken = 1'b0;

    if (uses_mem) begin
      for (int c = 0; c <= mw; c++) begin
        i_dmem_ready = (c == mw);
        #1;
        check("mem_req", o_dmem_req, 1);
        check("mem_write", o_mem_write, (k == K_S));
        check("mem_no_rf", o_reg_write, 0);
        check("mem_pc_write", o_pc_write, (k == K_S) && (c == mw));
        check("mem_pc_src", o_pc_src, 0);
        @(negedge i_clk);
      end
      i_dmem_ready = 1'b0;
      if (k == K_S) exp_instret++;
    end

    if (writes_rd) begin
      #1;
      check("wb_reg_write", o_reg_write, 1);
      check("wb_src", o_reg_write_src, links ? 2'b01 : ((k == K_LOAD) ? 2'b00 : 2'b10));
      check("wb_pc_write", o_pc_write, 1);
      check("wb_pc_src", o_pc_src, links);
      check("wb_no_mem", {o_dmem_req, o_mem_write}, 2'b00);
      exp_instret++;
      @(negedge i_clk);
    end

    #1;
    check("instret", o_instret, exp_instret);
    check("next_fetch", {o_imem_req, o_trap}, 2'b10);
  endtask

  task automatic check_trap(input logic [1:0] cause);
    for (int c = 0; c < 3; c++) begin
      i_imem_ready   = 1'($urandom_range(0, 1));
      i_dmem_ready   = 1'($urandom_range(0, 1));
      i_branch_taken = 1'($urandom_range(0, 1));
      i_format       = 6'($urandom);
      #1;
      check("trap_flag", o_trap, 1);
      check("trap_cause", o_trap_cause, cause);
      check("trap_quiet", strobes(), 16'h0);
      @(negedge i_clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    logic [5:0] fmt;
    #2;
    do_reset();

    run_instr(K_R,    3'b000, 0, 0, 1'b0);
    run_instr(K_LOAD, 3'b010, 1, 2, 1'b0);
    run_instr(K_S,    3'b010, 0, 1, 1'b0);
    run_instr(K_B,    3'b000, 0, 0, 1'b1);
    run_instr(K_B,    3'b001, 2, 0, 1'b0);
    run_instr(K_JALR, 3'b000, 0, 0, 1'b0);
    run_instr(K_J,    3'b101, 0, 0, 1'b0);
    run_instr(K_U,    3'b011, 0, 0, 1'b0);
    run_instr(K_I,    3'b111, 0, 0, 1'b0);
    run_instr(K_R,    3'b100, TO - 1, 0, 1'b0);
    run_instr(K_LOAD, 3'b000, 0, TO - 1, 1'b0);
    run_instr(K_S,    3'b001, 3, TO - 1, 1'b0);

    for (int n = 0; n < 50; n++) begin
      run_instr(kind_e'($urandom_range(0, 7)), 3'($urandom), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    encode(K_LOAD, op, fmt);
    fetch_decode(op, 3'b010, fmt, 0);
    #1;
    @(negedge i_clk);
    i_dmem_ready = 1'b0;
    #1;
    check("pre_reset_req", o_dmem_req, 1);
    #2;
    do_reset();

    fetch_decode(7'b0110011, 3'b000, 6'b000011, 0);
    check_trap(2'b01);
    do_reset();
    fetch_decode(7'b0110011, 3'b000, 6'b000000, 0);
    check_trap(2'b01);
    do_reset();

    for (int c = 0; c < int'(TO); c++) begin
      i_imem_ready = 1'b0;
      #1;
      check("to_fetch_req", {o_imem_req, o_trap}, 2'b10);
      @(negedge i_clk);
    end
    check_trap(2'b10);
    do_reset();

    encode(K_S, op, fmt);
    fetch_decode(op, 3'b000, fmt, 0);
    #1;
    @(negedge i_clk);
    for (int c = 0; c < int'(TO); c++) begin
      i_dmem_ready = 1'b0;
      #1;
      check("to_mem_req", {o_dmem_req, o_mem_write, o_trap}, 3'b110);
      @(negedge i_clk);
    end
    check_trap(2'b11);
    do_reset();

    run_instr(K_R, 3'b110, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
